s27_lane_array: RTL
===================

Name: s27_lane_array

Overview:
- Parametrised, fully sequential successor to the s27 benchmark core: NUM_LANES independent s27 state machines, each with its 3 state flops (G5, G6, G7) held inside the block.
- Adds three things the single-lane combinational core lacks: valid-qualified stepping, a full-width scan chain over all state bits, and a per-lane saturating G17 event counter.
- Used as the sequential reference/stress target for mapper regression, as a drop-in multi-lane netlist.

Parameters:
- NUM_LANES, 4, number of independent s27 lanes (≥1).
- CNT_W, 8, width of each lane's G17 event counter (≥1).
- RST_STATE, 3'b000, reset value of {G7,G6,G5} in every lane.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  step all lanes with in_pi this cycle.
- in_pi  in  4*NUM_LANES  lane i primary inputs: bits [4i+3:4i] = {G3,G2,G1,G0}.
- scan_en  in  1  shift mode; has priority over in_valid.
- scan_in  in  1  serial state input.
- scan_out  out  1  serial state output, = state_q[3*NUM_LANES-1].
- cnt_clr  in  1  synchronous clear of all counters.
- out_valid  out  1  out_g17 holds the result of the previous accepted step.
- out_g17  out  NUM_LANES  registered G17 per lane.
- state_q  out  3*NUM_LANES  lane i state: bits [3i+2:3i] = {G7,G6,G5}.
- g17_cnt  out  CNT_W*NUM_LANES  lane i counter at bits [CNT_W*i +: CNT_W].

Behaviour:
- Per-lane combinational core:
  - n9 = ~G0 & G6 & ~G5
  - n12 = ~G1 & ~G7 & G3 & ~G5
  - G17 = ~n9 & ~n12
  - next G5 = G0 & G17
  - next G6 = ~G17
  - next G7 = ~G2 & (G1 | G7)
- Reset (async assert, sync release):
  - state_q = RST_STATE replicated in every lane.
  - out_g17 = 0, out_valid = 0, all g17_cnt = 0.
- Operating modes, evaluated per cycle in priority order:
  - scan_en=1:
    - state_q <= {state_q[3N-2:0], scan_in}.
    - out_valid <= 0; out_g17 and counters hold.
    - in_valid is ignored.
  - scan_en=0, in_valid=1 (accepted step):
    - each lane's state_q <= its next-state.
    - out_g17[i] <= G17 of lane i, computed from pre-edge state and in_pi.
    - out_valid <= 1.
  - otherwise:
    - state, out_g17 and counters hold; out_valid <= 0.
- Latency: out_g17 and out_valid appear the cycle after acceptance. out_valid is a single-cycle pulse per accepted step; back-to-back in_valid keeps it high.
- Counters, per lane:
  - Increment on an accepted step whose G17=1.
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr=1 forces 0 and wins over a simultaneous increment.
  - cnt_clr is honoured in scan mode too.
- scan_out is a direct register tap, with no extra stage. A full chain load takes 3*NUM_LANES shift cycles.
- Reset mid-scan or mid-step: all registers return to reset values immediately. A partial shift is discarded.
- Lanes never interact except through the scan chain.

Decomposition:
- Shared package s27_pkg holds:
  - localparam ST_W=3, PI_W=4.
  - Bit-index constants G5_IDX=0, G6_IDX=1, G7_IDX=2.
  - Input-index constants G0..G3.
  - Function s27_next(state, pi), returning {next_state, g17}.
- One sub-module, s27_lane: a single lane's state flops, next-state logic and counter. It is instantiated NUM_LANES times via generate.
- The top level owns:
  - the scan chain muxing;
  - out_valid;
  - the output concatenation.

Test Plan:
- Reset and step, NUM_LANES=1, CNT_W=8: after reset (state 000), in_valid=1 with pi {G3,G2,G1,G0}=4'b1001 -> next cycle out_g17=0, out_valid=1, state_q=3'b010, g17_cnt=0.
- Sequence: from state 010, pi=4'b0010 -> out_g17=0, state_q=3'b110. Separately, from 000 with pi=4'b0111 -> out_g17=1, state_q=3'b001, g17_cnt=1.
- Saturation, CNT_W=2: repeat a G17=1 step five times -> g17_cnt sticks at 3. Then cnt_clr and in_valid together on a G17=1 step -> g17_cnt=0.
- Scan, NUM_LANES=2:
  - Shift in 6'b101100 MSB-first over 6 cycles with scan_en=1 -> state_q=6'b101100, out_valid=0 throughout.
  - Next 6 shifts -> scan_out emits 1,0,1,1,0,0.
  - in_valid asserted during the scan is ignored.
- Lane independence, NUM_LANES=4: drive a different pi per lane -> each lane's state and G17 match a golden single-lane model. Randomised for 10k steps with random gaps in in_valid.
- Reset mid-operation: assert rst_n=0 asynchronously between edges during a scan -> all outputs go to reset values before the next edge; state_q=RST_STATE in every lane.

Source files
------------

// File: rtl/s27_pkg.sv
// Shared constants and the s27 next-state function used by every lane.
package s27_pkg;

  localparam int ST_W = 3;
  localparam int PI_W = 4;

  // Bit positions inside a lane's state word {G7,G6,G5}
  localparam int G5_IDX = 0;
  localparam int G6_IDX = 1;
  localparam int G7_IDX = 2;

  // Bit positions inside a lane's primary-input word {G3,G2,G1,G0}
  localparam int G0_IDX = 0;
  localparam int G1_IDX = 1;
  localparam int G2_IDX = 2;
  localparam int G3_IDX = 3;

  // Returns {next {G7,G6,G5}, G17} for one lane
  function automatic logic [ST_W:0] s27_next(input logic [ST_W-1:0] st,
                                             input logic [PI_W-1:0] pi);
    logic n9, n12, g17;
    logic [ST_W-1:0] ns;
    n9  = ~pi[G0_IDX] & st[G6_IDX] & ~st[G5_IDX];
    n12 = ~pi[G1_IDX] & ~st[G7_IDX] & pi[G3_IDX] & ~st[G5_IDX];
    g17 = ~n9 & ~n12;
    ns[G5_IDX] = pi[G0_IDX] & g17;
    ns[G6_IDX] = ~g17;
    ns[G7_IDX] = ~pi[G2_IDX] & (pi[G1_IDX] | st[G7_IDX]);
    return {ns, g17};
  endfunction

endpackage

// File: rtl/s27_lane.sv
// One s27 lane: state flops, registered G17 and a saturating G17 counter.
// The shifted-in state word is prepared by the parent so the scan chain
// wiring stays in one place.
module s27_lane
  import s27_pkg::*;
#(
  parameter int              CNT_W     = 8,
  parameter logic [ST_W-1:0] RST_STATE = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             shift_i,
  input  logic [ST_W-1:0]  shift_st_i,
  input  logic             cnt_clr_i,
  input  logic [PI_W-1:0]  pi_i,
  output logic [ST_W-1:0]  state_o,
  output logic             g17_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [ST_W-1:0]  state_q;
  logic             g17_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ST_W:0]    nxt;
  logic             accept;

  assign nxt    = s27_next(state_q, pi_i);
  // Shifting always wins over stepping
  assign accept = step_i & ~shift_i;

  // Counter next value: clear beats increment, increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (accept && nxt[0] && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, G17 and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      g17_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (shift_i) begin
        state_q <= shift_st_i;
      end else if (step_i) begin
        state_q <= nxt[ST_W:1];
      end
      if (accept) begin
        g17_q <= nxt[0];
      end
      cnt_q <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign g17_o   = g17_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/s27_lane_array.sv
// NUM_LANES independent s27 lanes with a shared scan chain over all state
// bits, a common output-valid flag and per-lane G17 event counters.
module s27_lane_array
  import s27_pkg::*;
#(
  parameter int              NUM_LANES = 4,
  parameter int              CNT_W     = 8,
  parameter logic [ST_W-1:0] RST_STATE = 3'b000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [PI_W*NUM_LANES-1:0]  in_pi,
  input  logic                       scan_en,
  input  logic                       scan_in,
  output logic                       scan_out,
  input  logic                       cnt_clr,
  output logic                       out_valid,
  output logic [NUM_LANES-1:0]       out_g17,
  output logic [ST_W*NUM_LANES-1:0]  state_q,
  output logic [CNT_W*NUM_LANES-1:0] g17_cnt
);

  localparam int SW = ST_W * NUM_LANES;

  logic          out_valid_q;
  logic [SW-1:0] shift_d;
  logic          step;

  // Whole-chain shift: scan_in enters at bit 0, bit SW-1 leaves on scan_out
  assign shift_d  = {state_q[SW-2:0], scan_in};
  assign scan_out = state_q[SW-1];
  assign step     = in_valid & ~scan_en;

  // out_valid pulses for one cycle after each accepted step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= step;
    end
  end

  assign out_valid = out_valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      s27_lane #(
        .CNT_W     (CNT_W),
        .RST_STATE (RST_STATE)
      ) u_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (step),
        .shift_i    (scan_en),
        .shift_st_i (shift_d[ST_W*gi +: ST_W]),
        .cnt_clr_i  (cnt_clr),
        .pi_i       (in_pi[PI_W*gi +: PI_W]),
        .state_o    (state_q[ST_W*gi +: ST_W]),
        .g17_o      (out_g17[gi]),
        .cnt_o      (g17_cnt[CNT_W*gi +: CNT_W])
      );
    end
  endgenerate

endmodule
